// File: rtl/ff_bank_if.sv
// Handshake-free bus for the ff_bank flip-flop array: control/data in, state and flags out.
interface ff_bank_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic [WIDTH-1:0] changed;
   logic [WIDTH-1:0] sr_invalid;
   logic             sticky_err;

   modport master (
      output en, mode, a, b,
      input  q, qb, changed, sr_invalid, sticky_err
   );

   modport slave (
      input  en, mode, a, b,
      output q, qb, changed, sr_invalid, sticky_err
   );
endinterface

// File: rtl/ff_bank.sv
// Bank of WIDTH independent D/T/SR/JK flip-flops with change flags and SR-illegal detection.
// One-cycle latency, all outputs registered (qb is ~q); no backpressure, en=0 holds state.
module ff_bank #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic         clock,
   input  logic         reset,
   ff_bank_if.slave     bus
);

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_SR = 2'b10,
      MODE_JK = 2'b11
   } mode_t;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] changed_r;
   logic [WIDTH-1:0] sr_invalid_r;
   logic             sticky_r;

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] inv_next;

   always_comb begin
      q_next   = q_r;
      inv_next = '0;
      case (mode_t'(bus.mode))
         MODE_D:  q_next = bus.a;
         MODE_T:  q_next = q_r ^ bus.a;
         MODE_SR: begin
            // a=b=1 is illegal: the bit holds and is flagged
            q_next   = (bus.a & ~bus.b) | (q_r & ~(~bus.a & bus.b));
            inv_next = bus.a & bus.b;
         end
         MODE_JK: q_next = (bus.a & ~q_r) | (~bus.b & q_r);
         default: q_next = q_r;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_r          <= RESET_VALUE;
         changed_r    <= '0;
         sr_invalid_r <= '0;
         sticky_r     <= 1'b0;
      end else if (bus.en) begin
         q_r          <= q_next;
         changed_r    <= q_next ^ q_r;
         sr_invalid_r <= inv_next;
         sticky_r     <= sticky_r | (|inv_next);
      end else begin
         changed_r    <= '0;
         sr_invalid_r <= '0;
      end
   end

   assign bus.q          = q_r;
   assign bus.qb         = ~q_r;
   assign bus.changed    = changed_r;
   assign bus.sr_invalid = sr_invalid_r;
   assign bus.sticky_err = sticky_r;

endmodule

// File: tb/tb_ff_bank.sv
// Directed vector bench for ff_bank with WIDTH=4, RESET_VALUE=4'b1010.
module tb_ff_bank;
   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'b1010;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ff_bank_if #(.WIDTH(W)) bus ();

   ff_bank #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] chg;
      logic [3:0] inv;
      logic       sticky;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic drive_step(input logic r, input logic e, input logic [1:0] m,
                             input logic [3:0] av, input logic [3:0] bv);
      @(negedge clock);
      reset    = r;
      bus.en   = e;
      bus.mode = m;
      bus.a    = av;
      bus.b    = bv;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all(input int idx, input logic [3:0] eq, input logic [3:0] ec,
                          input logic [3:0] ei, input logic es);
      chk("q", idx, bus.q, eq);
      chk("qb", idx, bus.qb, ~eq);
      chk("changed", idx, bus.changed, ec);
      chk("sr_invalid", idx, bus.sr_invalid, ei);
      chk("sticky_err", idx, {3'b000, bus.sticky_err}, {3'b000, es});
   endtask

   initial begin
      // rst en mode a b | q changed sr_invalid sticky
      tbl[0]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 2'b00, 4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b0000, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 2'b01, 4'b0011, 4'b1111, 4'b0101, 4'b0011, 4'b0000, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 2'b01, 4'b0000, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2'b10, 4'b1100, 4'b0101, 4'b1000, 4'b1000, 4'b0100, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 2'b00, 4'b1010, 4'b0000, 4'b1010, 4'b0010, 4'b0000, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 2'b11, 4'b1100, 4'b0110, 4'b1100, 4'b0110, 4'b0000, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0000, 4'b0101, 4'b1001, 4'b0000, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 2'b01, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 2'b10, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b0000, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 2'b01, 4'b1111, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b0000, 1'b0};
      // reset must beat an SR-illegal input; the release edge then sees it
      tbl[17] = '{1'b1, 1'b1, 2'b10, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b0000, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 2'b10, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b1111, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 2'b10, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b0000, 1'b1};

      reset    = 1'b1;
      bus.en   = 1'b1;
      bus.mode = 2'b00;
      bus.a    = 4'b0000;
      bus.b    = 4'b0000;

      for (int i = 0; i < 2; i++) begin
         drive_step(1'b1, 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
         chk_all(100 + i, RV, 4'b0000, 4'b0000, 1'b0);
      end

      for (int i = 0; i < 20; i++) begin
         drive_step(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b);
         chk_all(i, tbl[i].q, tbl[i].chg, tbl[i].inv, tbl[i].sticky);
      end

      // inputs changing between edges must not reach the outputs
      @(negedge clock);
      bus.en   = 1'b1;
      bus.mode = 2'b00;
      bus.a    = 4'b0101;
      #2;
      chk("no_comb_path_q", 200, bus.q, 4'b1010);
      chk("no_comb_path_chg", 200, bus.changed, 4'b0000);
      @(posedge clock);
      #1;
      chk("after_edge_q", 201, bus.q, 4'b0101);
      chk("after_edge_chg", 201, bus.changed, 4'b1111);

      // back-to-back mode switch D -> JK toggle -> SR with no dead cycle
      drive_step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111);
      chk("jk_toggle_q", 202, bus.q, 4'b1010);
      drive_step(1'b0, 1'b1, 2'b10, 4'b0001, 4'b1000);
      chk("sr_switch_q", 203, bus.q, 4'b0011);
      chk("sr_switch_chg", 203, bus.changed, 4'b1001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, expected finish before 20000");
      $fatal(1);
   end
endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH independent edge-triggered flip-flops. Each cycle, a mode input makes every bit behave as a D, T, SR or JK flip-flop. This generalises the single T flip-flop in the sequential-circuits set. Every output is registered, and the bank also reports per-bit change flags, SR-illegal-input detection and a sticky error bit. It serves as the common storage primitive for the counters and shift registers built on top of it in the same lab set.

## Interface
- WIDTH, 8, number of flip-flop channels (≥1)
- RESET_VALUE, '0, WIDTH-bit value loaded into q on reset
- clock  input  1  rising-edge clock; all state updates on this edge
- reset  input  1  one clock; reset is synchronous and active-high
- en  input  1  update enable; 0 = hold all state
- mode  input  2  00 D, 01 T, 10 SR, 11 JK; applies to all bits this cycle
- a  input  WIDTH  per-bit D / T / S / J input, depending on mode
- b  input  WIDTH  per-bit R / K input; ignored in D and T modes
- q  output  WIDTH  flip-flop state
- qb  output  WIDTH  always bitwise ~q, including during and after reset
- changed  output  WIDTH  registered; bit i = 1 if q[i] changed at the last edge
- sr_invalid  output  WIDTH  registered; bit i = 1 if the last edge saw SR mode with a[i]=b[i]=1 and en=1
- sticky_err  output  1  set when any sr_invalid bit is set; cleared only by reset

## Operation
- Next-state per bit i, when en=1 and reset=0:
  - D: q ← a
  - T: q ← q ^ a
  - SR: a=1,b=0 → 1; a=0,b=1 → 0; a=b=0 → hold; a=b=1 → hold and flag sr_invalid[i]
  - JK: 00 hold, 10 set, 01 clear, 11 toggle
- Bits are fully independent. The SR illegal case on one bit does not affect any other bit.
- changed = q_next ^ q_current, registered at the same edge as q.
- sticky_err ← sticky_err | (|sr_invalid_next).
- en=0: q holds, changed ← 0, sr_invalid ← 0, sticky_err holds. mode, a and b are don't-care.
- Reset values: q=RESET_VALUE, qb=~RESET_VALUE, changed=0, sr_invalid=0, sticky_err=0.
- Reset dominates en and mode. A reset mid-sequence discards that cycle's inputs.
- The release edge (first edge with reset=0) behaves as a normal update from RESET_VALUE.

## Timing
- Inputs are sampled at the rising edge of clock. Outputs change one clock after sampling, with no combinational input-to-output path.
- q, changed, sr_invalid and sticky_err update at the same edge. qb tracks q with zero added cycles.
- Reset takes effect at the first rising edge with reset=1. Outputs stay at reset values while reset is held.
- A mode change between consecutive cycles takes effect on the very next edge, with no dead cycle.
- changed reflects the reset-edge transition as 0, even if q moved to RESET_VALUE at that edge.

## Test plan
- Reset: WIDTH=4, RESET_VALUE=4'b1010, reset=1 for 2 cycles with random a, b and mode → q=1010, qb=0101, changed=0, sr_invalid=0, sticky_err=0.
- D and T modes, from q=0000:
  - mode=00, a=0110 → q=0110, changed=0110.
  - Then mode=01, a=0011 → q=0101, changed=0011.
  - Then mode=01, a=0000 → q=0101, changed=0000.
- SR mode, from q=0000:
  - mode=10, a=1100, b=0101 → q=1000, sr_invalid=0100, sticky_err=1.
  - Then mode=10, a=0000, b=0000 → q=1000, sr_invalid=0000, sticky_err stays 1.
- JK mode, from q=1010: mode=11, a=1100, b=0110 → q=1100 (bit3 set kept 1, bit2 toggled 0→1, bit1 cleared 1→0, bit0 hold 0), changed=0110.
- Enable and hold: q=0101, en=0, mode=01, a=1111 for 3 cycles → q=0101, changed=0000, sr_invalid=0000. Then en=1 → q=1010.
- Reset mid-operation:
  - Toggle all bits each cycle (T mode, a=1111), then assert reset for one cycle → q=RESET_VALUE, sticky_err=0.
  - Next cycle with T mode, a=1111 → q=~RESET_VALUE, changed=1111.
